// File: rtl/ucode_sequencer.sv
// Microprogrammed control unit with a loadable control store and an opcode dispatch table.
// Each store entry is {ctrl, seq[1:0], next}; each dispatch entry is {valid, target}.
module ucode_sequencer #(
    parameter int CW_WIDTH  = 14,
    parameter int UPC_WIDTH = 4,
    parameter int OP_WIDTH  = 6,
    parameter int AW        = (UPC_WIDTH > OP_WIDTH) ? UPC_WIDTH : OP_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stall,
    input  logic [OP_WIDTH-1:0]           opcode,
    input  logic                          ld_we,
    input  logic                          ld_sel,
    input  logic [AW-1:0]                 ld_addr,
    input  logic [CW_WIDTH+2+UPC_WIDTH-1:0] ld_data,
    output logic [CW_WIDTH-1:0]           ctrl,
    output logic [UPC_WIDTH-1:0]          upc,
    output logic                          running,
    output logic                          err
);

    localparam int EW          = CW_WIDTH + 2 + UPC_WIDTH;
    localparam int STORE_DEPTH = 1 << UPC_WIDTH;
    localparam int DISP_DEPTH  = 1 << OP_WIDTH;

    localparam logic [1:0] SEQ_INC  = 2'b00;
    localparam logic [1:0] SEQ_JMP  = 2'b01;
    localparam logic [1:0] SEQ_DISP = 2'b10;

    localparam logic [UPC_WIDTH-1:0] UPC_ONE = {{(UPC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [UPC_WIDTH-1:0]   upc_q, upc_d;
    logic [CW_WIDTH-1:0]    ctrl_q, ctrl_d;
    logic                   err_q, err_d;
    logic [DISP_DEPTH-1:0]  disp_valid_q, disp_valid_d;

    // Table contents deliberately have no reset so a loaded microprogram survives rst_n.
    logic [EW-1:0]          store_mem [STORE_DEPTH];
    logic [UPC_WIDTH-1:0]   disp_target_mem [DISP_DEPTH];

    logic                   load_ok;
    logic                   store_we;
    logic                   disp_we;
    logic [EW-1:0]          cur_entry;
    logic [1:0]             cur_seq;
    logic [UPC_WIDTH-1:0]   cur_next;
    logic                   disp_hit;
    logic [UPC_WIDTH-1:0]   disp_target;
    logic [UPC_WIDTH-1:0]   upc_n;
    logic [UPC_WIDTH-1:0]   fetch_addr;
    logic                   advance;

    assign load_ok  = (state_q == ST_HALT) && ld_we && !start;
    assign store_we = load_ok && !ld_sel;
    assign disp_we  = load_ok && ld_sel;

    assign cur_entry   = store_mem[upc_q];
    assign cur_seq     = cur_entry[UPC_WIDTH +: 2];
    assign cur_next    = cur_entry[UPC_WIDTH-1:0];
    assign disp_hit    = disp_valid_q[opcode];
    assign disp_target = disp_target_mem[opcode];

    always_ff @(posedge clk) begin
        if (store_we) begin
            store_mem[ld_addr[UPC_WIDTH-1:0]] <= ld_data;
        end
        if (disp_we) begin
            disp_target_mem[ld_addr[OP_WIDTH-1:0]] <= ld_data[UPC_WIDTH-1:0];
        end
    end

    always_comb begin
        disp_valid_d = disp_valid_q;
        if (disp_we) begin
            disp_valid_d[ld_addr[OP_WIDTH-1:0]] = ld_data[UPC_WIDTH];
        end
    end

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        ctrl_d     = ctrl_q;
        err_d      = err_q;
        upc_n      = upc_q + UPC_ONE;
        fetch_addr = '0;
        advance    = 1'b0;

        if (state_q == ST_HALT) begin
            ctrl_d = '0;
            if (start) begin
                state_d = ST_RUN;
                upc_d   = '0;
                err_d   = 1'b0;
                advance = 1'b1;
            end
        end else if (!stall) begin
            case (cur_seq)
                SEQ_INC: begin
                    advance    = 1'b1;
                    fetch_addr = upc_n;
                end
                SEQ_JMP: begin
                    upc_n      = cur_next;
                    advance    = 1'b1;
                    fetch_addr = upc_n;
                end
                SEQ_DISP: begin
                    if (disp_hit) begin
                        upc_n      = disp_target;
                        advance    = 1'b1;
                        fetch_addr = upc_n;
                    end else begin
                        state_d = ST_HALT;
                        ctrl_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    ctrl_d  = '0;
                    upc_d   = '0;
                end
            endcase
            if (advance) begin
                upc_d = upc_n;
            end
        end

        if (advance) begin
            ctrl_d = store_mem[fetch_addr][EW-1 -: CW_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HALT;
            upc_q        <= '0;
            ctrl_q       <= '0;
            err_q        <= 1'b0;
            disp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            upc_q        <= upc_d;
            ctrl_q       <= ctrl_d;
            err_q        <= err_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign upc     = upc_q;
    assign running = (state_q == ST_RUN);
    assign err     = err_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: a table-level behavioural model is checked every
// falling edge, and literal expectations pin the key sequences.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [5:0]  opcode = '0;
    logic        ld_we = 1'b0;
    logic        ld_sel = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [19:0] ld_data = '0;
    logic [13:0] ctrl;
    logic [3:0]  upc;
    logic        running;
    logic        err;

    int checks = 0;
    int failures = 0;

    ucode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .ctrl(ctrl), .upc(upc), .running(running), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: tables as plain arrays, sequencing from the micro-op rules.
    logic [13:0] m_cw   [16];
    logic [1:0]  m_seq  [16];
    logic [3:0]  m_nx   [16];
    logic        m_valid[64];
    logic [3:0]  m_tgt  [64];
    logic        m_run;
    int          m_upc;
    logic [13:0] m_ctrl;
    logic        m_err;
    int          m_n;
    bit          m_go;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_upc = 0; m_ctrl = '0; m_err = 1'b0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_upc = 0; m_ctrl = m_cw[0]; m_err = 1'b0;
            end else if (ld_we) begin
                if (!ld_sel) begin
                    m_cw[ld_addr % 16]  = ld_data[19:6];
                    m_seq[ld_addr % 16] = ld_data[5:4];
                    m_nx[ld_addr % 16]  = ld_data[3:0];
                end else begin
                    m_valid[ld_addr] = ld_data[4];
                    m_tgt[ld_addr]   = ld_data[3:0];
                end
            end
        end else if (!stall) begin
            m_go = 1'b1;
            m_n  = 0;
            case (m_seq[m_upc])
                2'd0: m_n = (m_upc + 1) % 16;
                2'd1: m_n = m_nx[m_upc];
                2'd2: begin
                    if (m_valid[opcode]) m_n = m_tgt[opcode];
                    else begin m_run = 1'b0; m_ctrl = '0; m_err = 1'b1; m_go = 1'b0; end
                end
                default: begin m_run = 1'b0; m_ctrl = '0; m_upc = 0; m_go = 1'b0; end
            endcase
            if (m_go) begin
                m_upc  = m_n;
                m_ctrl = m_cw[m_n];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_ctrl", {18'd0, ctrl}, {18'd0, m_ctrl});
            chk("mdl_upc", {28'd0, upc}, m_upc);
            chk("mdl_running", {31'd0, running}, {31'd0, m_run});
            chk("mdl_err", {31'd0, err}, {31'd0, m_err});
        end
    end

    function automatic logic [19:0] ent(input logic [13:0] c, input logic [1:0] s, input logic [3:0] n);
        return {c, s, n};
    endfunction

    function automatic logic [19:0] dent(input logic v, input logic [3:0] t);
        return {15'd0, v, t};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ld(input logic sel, input logic [5:0] addr, input logic [19:0] data);
        ld_sel = sel; ld_addr = addr; ld_data = data; ld_we = 1'b1;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [13:0] c, input logic [3:0] u,
                              input logic r, input logic e);
        chk({name, "_ctrl"}, {18'd0, ctrl}, {18'd0, c});
        chk({name, "_upc"}, {28'd0, upc}, {28'd0, u});
        chk({name, "_run"}, {31'd0, running}, {31'd0, r});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall = i[0];
            tick();
        end
        stall = 1'b0;
        expect_out("idle", 14'h0, 4'h0, 1'b0, 1'b0);

        // Linear fetch
        ld(1'b0, 6'd0, ent(14'h3021, 2'b00, 4'h0));
        ld(1'b0, 6'd1, ent(14'h0100, 2'b01, 4'h2));
        ld(1'b0, 6'd2, ent(14'h0000, 2'b11, 4'h0));
        pulse_start();
        expect_out("lin0", 14'h3021, 4'd0, 1'b1, 1'b0);
        tick(); expect_out("lin1", 14'h0100, 4'd1, 1'b1, 1'b0);
        tick(); expect_out("lin2", 14'h0000, 4'd2, 1'b1, 1'b0);
        tick(); expect_out("lin3", 14'h0000, 4'd0, 1'b0, 1'b0);

        // Dispatch, valid opcode
        ld(1'b0, 6'd1, ent(14'h0020, 2'b10, 4'h0));
        ld(1'b1, 6'h23, dent(1'b1, 4'h5));
        ld(1'b0, 6'd5, ent(14'h0102, 2'b11, 4'h0));
        opcode = 6'h23;
        pulse_start();
        expect_out("dsp0", 14'h3021, 4'd0, 1'b1, 1'b0);
        tick(); expect_out("dsp1", 14'h0020, 4'd1, 1'b1, 1'b0);
        tick(); expect_out("dsp2", 14'h0102, 4'd5, 1'b1, 1'b0);
        tick(); expect_out("dsp3", 14'h0000, 4'd0, 1'b0, 1'b0);

        // Dispatch, invalid opcode
        opcode = 6'h3F;
        pulse_start();
        tick(); expect_out("ill1", 14'h0020, 4'd1, 1'b1, 1'b0);
        tick(); chk("ill_ctrl", {18'd0, ctrl}, 32'h0);
        chk("ill_run", {31'd0, running}, 32'h0);
        chk("ill_err", {31'd0, err}, 32'h1);

        // Restart clears err; stall on the dispatch micro-op
        opcode = 6'h23;
        pulse_start();
        expect_out("stl0", 14'h3021, 4'd0, 1'b1, 1'b0);
        tick(); expect_out("stl1", 14'h0020, 4'd1, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stl_hold", 14'h0020, 4'd1, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); expect_out("stl2", 14'h0102, 4'd5, 1'b1, 1'b0);
        tick(); expect_out("stl3", 14'h0000, 4'd0, 1'b0, 1'b0);

        // Wrap via dispatch to 15; loads during RUN must be ignored
        ld(1'b0, 6'd0, ent(14'h3021, 2'b10, 4'h0));
        ld(1'b1, 6'h10, dent(1'b1, 4'hF));
        ld(1'b0, 6'd15, ent(14'h1500, 2'b00, 4'h0));
        opcode = 6'h10;
        pulse_start();
        expect_out("wrp0", 14'h3021, 4'd0, 1'b1, 1'b0);
        ld_sel = 1'b0; ld_addr = 6'd2; ld_data = ent(14'h3FFF, 2'b00, 4'h7); ld_we = 1'b1;
        tick(); expect_out("wrp1", 14'h1500, 4'd15, 1'b1, 1'b0);
        ld_sel = 1'b1; ld_addr = 6'h3F; ld_data = dent(1'b1, 4'h1);
        tick(); expect_out("wrp2", 14'h3021, 4'd0, 1'b1, 1'b0);
        ld_we = 1'b0;
        opcode = 6'h3F;
        tick(); expect_out("wrp3", 14'h0000, 4'd0, 1'b0, 1'b1);

        // Store entry 2 intact; a load coinciding with start is also dropped
        ld(1'b0, 6'd0, ent(14'h3021, 2'b00, 4'h0));
        ld(1'b0, 6'd1, ent(14'h0100, 2'b01, 4'h2));
        ld_sel = 1'b0; ld_addr = 6'd2; ld_data = ent(14'h2AAA, 2'b00, 4'h0); ld_we = 1'b1;
        pulse_start();
        ld_we = 1'b0;
        expect_out("chk0", 14'h3021, 4'd0, 1'b1, 1'b0);
        tick(); expect_out("chk1", 14'h0100, 4'd1, 1'b1, 1'b0);
        tick(); expect_out("chk2", 14'h0000, 4'd2, 1'b1, 1'b0);
        tick(); expect_out("chk3", 14'h0000, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset while parked at upc 5
        ld(1'b0, 6'd1, ent(14'h0020, 2'b10, 4'h0));
        ld(1'b0, 6'd5, ent(14'h0102, 2'b01, 4'h5));
        ld(1'b1, 6'h23, dent(1'b1, 4'h5));
        opcode = 6'h23;
        pulse_start();
        tick(); tick(); tick();
        expect_out("park", 14'h0102, 4'd5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_out("arst", 14'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        expect_out("post0", 14'h3021, 4'd0, 1'b1, 1'b0);
        tick(); expect_out("post1", 14'h0020, 4'd1, 1'b1, 1'b0);
        tick(); expect_out("post2", 14'h0000, 4'd1, 1'b0, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Parametrised microprogrammed control unit for the multi-cycle CPU. A loadable control store emits one control word per cycle. Per-instruction sequencing comes from next-address fields and an opcode dispatch table, so a new instruction set changes table contents, not RTL. The registered control word feeds the existing field-splitting logic that drives PC, IR, register-file, ALU and memory enables. Stall and halt support let multi-cycle memory accesses hold the datapath.

## Interface
Parameters:
- CW_WIDTH, 14, control-word width (bit 13 = PC write … bit 0 = branch in the default map)
- UPC_WIDTH, 4, microprogram-counter width; control store depth 2^UPC_WIDTH
- OP_WIDTH, 6, opcode width; dispatch table depth 2^OP_WIDTH
- AW, max(UPC_WIDTH,OP_WIDTH), load-address width (derived)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin execution at µPC 0
- stall  in  1  hold µPC and control word this cycle
- opcode  in  OP_WIDTH  opcode used by dispatch micro-ops
- ld_we  in  1  table write strobe
- ld_sel  in  1  0 = control store, 1 = dispatch table
- ld_addr  in  AW  table address; upper bits ignored for the smaller table
- ld_data  in  CW_WIDTH+2+UPC_WIDTH  store entry {ctrl, seq[1:0], next}; dispatch entry uses ld_data[UPC_WIDTH:0] = {valid, target}
- ctrl  out  CW_WIDTH  registered control word
- upc  out  UPC_WIDTH  current µPC
- running  out  1  high in RUN
- err  out  1  sticky illegal-opcode flag

## Operation
- Two states: HALT, RUN. Reset: HALT, ctrl=0, upc=0, running=0, err=0, all dispatch valid bits 0. Control store contents are not reset.
- HALT:
  - ctrl held at 0.
  - ld_we writes the selected table at the edge.
  - start → RUN; upc←0, ctrl←store[0].ctrl. err cleared.
  - ld_we is ignored in a cycle where start=1.
  - stall is ignored.
- RUN:
  - ld_we is ignored. start is ignored.
  - stall=1: upc and ctrl hold.
  - stall=0: the current entry's seq selects the next µPC n:
    - 00 increment: n = upc+1, wrapping 2^UPC_WIDTH−1 → 0.
    - 01 jump: n = next.
    - 10 dispatch: sample opcode this cycle. If the table entry is valid, n = target. If invalid, → HALT, ctrl←0, err←1.
    - 11 halt: → HALT, ctrl←0, upc←0.
  - Otherwise upc←n, ctrl←store[n].ctrl.
- Tables are read combinationally from registers (or distributed RAM), so there is no read latency.
- Asynchronous reset at any point: immediate HALT with all outputs at reset values. Loaded tables survive, except that dispatch valid bits clear.

## Timing
- start sampled at edge k → ctrl = store[0].ctrl and running=1 after edge k.
- One micro-op per unstalled cycle; ctrl changes only at edges with running=1 and stall=0, or on leaving RUN.
- Dispatch latency: opcode sampled at the edge that leaves the dispatch micro-op; the target's ctrl is visible after that edge.
- Halt/illegal: ctrl=0 and running=0 after the edge that executes the 11 micro-op or the invalid dispatch; err rises at that same edge.
- stall asserted in the same cycle as a halt or dispatch micro-op defers that transition until stall drops.
- Table writes are visible to reads on the cycle after the write edge.

## Test plan
- Reset/idle: hold rst_n=0, then release without start → ctrl=0, upc=0, running=0, err=0 for 20 cycles; stall toggling has no effect.
- Linear fetch:
  - Load store[0]={0x3021,00,x}, store[1]={0x0100,01,2}, store[2]={0x0000,11,x}; pulse start.
  - ctrl sequence 0x3021, 0x0100, 0x0000, then running=0.
  - upc sequence 0, 1, 2, 0.
- Dispatch:
  - store[1]={0x0020,10,x}; dispatch[6'h23]={1,4'h5}; store[5]={0x0102,11,x}; opcode=0x23.
  - After start, ctrl goes 0x3021 → 0x0020 → 0x0102 → 0 and upc reaches 5.
  - Repeat with opcode=0x3F (invalid) → HALT the edge after dispatch, err=1, ctrl=0. Next start clears err.
- Stall: hold stall=1 for 3 cycles while upc=1 → upc and ctrl frozen for exactly 3 cycles, then the sequence resumes unchanged.
- Wrap and jump: with UPC_WIDTH=4, store[15].seq=00 → next upc=0. Writes with ld_we during RUN do not alter the stored entry (verified after halting).
- Reset mid-run: assert rst_n low asynchronously at upc=5 → outputs zero without waiting for clk. After start, store contents are intact and dispatch entries must be reloaded (err on an unreloaded opcode).
